// File: rtl/sparse_mac_pkg.sv
// Shared widths, beat formats and skid-buffer states for the sparse MAC front end.
package sparse_mac_pkg;

    localparam int SKIP_W  = 8;
    localparam int VALUE_W = 8;
    localparam int INDEX_W = 16;

    typedef struct packed {
        logic [SKIP_W-1:0]  skip;
        logic [VALUE_W-1:0] value;
    } sram_data_t;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [VALUE_W-1:0] value;
    } decoder_data_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    // Absolute position of a nonzero: wraps silently at 2^INDEX_W.
    function automatic logic [INDEX_W-1:0] abs_index(input logic [INDEX_W-1:0] cnt,
                                                     input logic [SKIP_W-1:0]  skip);
        return cnt + INDEX_W'(skip);
    endfunction

endpackage

// File: rtl/sparse_dec_skid.sv
// Generic 2-entry valid/ready skid buffer with a registered upstream ready and
// a registered head entry driving the downstream side.
module sparse_dec_skid
    import sparse_mac_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    skid_state_e state_q, state_d;
    T            head_q, head_d;
    T            skid_q, skid_d;
    logic        ready_q;
    logic        push, pop;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    skid_d  = in_data_i;
                    state_d = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            ready_q <= (state_d != SKID_FULL);
        end
    end

    // NOTE: the overflow entry is only read in SKID_FULL, so it needs no reset.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_d;
    end

    // Ready is forced low while reset is held so no beat is taken mid-reset.
    assign in_ready_o  = ready_q && !rst_i;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = head_q;

endmodule

// File: rtl/sparse_decoder.sv
// Expands run-length-coded (skip, value) beats into absolute (index, value) pairs
// using a running element counter, buffered through a 2-entry skid stage.
module sparse_decoder
    import sparse_mac_pkg::*;
(
    input  logic          mac_clk,
    input  logic          mac_rst,
    input  logic          sram_valid_i,
    output logic          sram_ready_o,
    input  sram_data_t    sram_data_i,
    output logic          decoder_valid_o,
    input  logic          decoder_ready_i,
    output decoder_data_t decoder_data_o
);

    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic [INDEX_W-1:0] idx;
    logic               accept;
    decoder_data_t      push_data;

    assign accept = sram_valid_i && sram_ready_o;
    assign idx    = abs_index(cnt_q, sram_data_i.skip);

    always_comb begin
        cnt_d           = cnt_q;
        push_data.index = idx;
        push_data.value = sram_data_i.value;
        if (accept) begin
            cnt_d = idx + INDEX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    sparse_dec_skid #(
        .T (decoder_data_t)
    ) u_skid (
        .clk_i       (mac_clk),
        .rst_i       (mac_rst),
        .in_valid_i  (sram_valid_i),
        .in_ready_o  (sram_ready_o),
        .in_data_i   (push_data),
        .out_valid_o (decoder_valid_o),
        .out_ready_i (decoder_ready_i),
        .out_data_o  (decoder_data_o)
    );

endmodule

// File: tb/tb_sparse_decoder.sv
// Scoreboard bench for sparse_decoder: a golden counter model predicts each
// accepted beat's output; DUT outputs are popped and compared in order.
module tb_sparse_decoder;
    import sparse_mac_pkg::*;

    logic          mac_clk = 1'b0;
    logic          mac_rst;
    logic          sram_valid_i;
    logic          sram_ready_o;
    sram_data_t    sram_data_i;
    logic          decoder_valid_o;
    logic          decoder_ready_i;
    decoder_data_t decoder_data_o;

    sparse_decoder dut (
        .mac_clk         (mac_clk),
        .mac_rst         (mac_rst),
        .sram_valid_i    (sram_valid_i),
        .sram_ready_o    (sram_ready_o),
        .sram_data_i     (sram_data_i),
        .decoder_valid_o (decoder_valid_o),
        .decoder_ready_i (decoder_ready_i),
        .decoder_data_o  (decoder_data_o)
    );

    always #5 mac_clk = ~mac_clk;

    int                 n_compared;
    int                 n_mismatched;
    decoder_data_t      exp_q[$];
    decoder_data_t      out_log[$];
    logic [INDEX_W-1:0] model_cnt;
    bit                 stall_pending;
    decoder_data_t      stall_data;
    bit                 accepted;
    int                 n_accept;
    int                 n_pop;

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic cycle(input bit v, input logic [SKIP_W-1:0] skip,
                         input logic [VALUE_W-1:0] val, input bit rdy);
        decoder_data_t e;
        decoder_data_t got;
        @(negedge mac_clk);
        sram_valid_i         = v;
        sram_data_i.skip     = skip;
        sram_data_i.value    = val;
        decoder_ready_i      = rdy;
        #1;
        if (stall_pending) begin
            n_compared++;
            if (decoder_valid_o !== 1'b1 || decoder_data_o !== stall_data) begin
                n_mismatched++;
                $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                         decoder_valid_o, decoder_data_o, stall_data);
            end
        end
        accepted = v && (sram_ready_o === 1'b1);
        if (accepted) begin
            e.index   = model_cnt + INDEX_W'(skip);
            e.value   = val;
            model_cnt = e.index + INDEX_W'(1);
            exp_q.push_back(e);
            n_accept++;
        end
        if (decoder_valid_o === 1'b1 && rdy) begin
            got = decoder_data_o;
            out_log.push_back(got);
            n_pop++;
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_output: got idx=%0h val=%0h, required no output",
                         got.index, got.value);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_mismatched++;
                    $display("FAIL scoreboard: got idx=%0h val=%0h, required idx=%0h val=%0h",
                             got.index, got.value, e.index, e.value);
                end
            end
        end
        stall_pending = (decoder_valid_o === 1'b1) && !rdy;
        stall_data    = decoder_data_o;
    endtask

    // rdy_mode: 0 = downstream stalled, 1 = ready, 2 = random ready each cycle.
    task automatic send(input logic [SKIP_W-1:0] skip, input logic [VALUE_W-1:0] val,
                        input int rdy_mode);
        bit rdy;
        for (int t = 0; t < 64; t++) begin
            rdy = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : (rdy_mode != 0);
            cycle(1'b1, skip, val, rdy);
            if (accepted) return;
        end
        n_compared++;
        n_mismatched++;
        $display("FAIL send_timeout: beat skip=%0d val=%0d not accepted, required accept within 64 cycles",
                 skip, val);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            cycle(1'b0, '0, '0, 1'b1);
            t++;
        end
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain_%s: %0d beats still expected, required 0", tag, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        @(negedge mac_clk);
        mac_rst         = 1'b1;
        sram_valid_i    = 1'b0;
        decoder_ready_i = 1'b0;
        sram_data_i     = '0;
        #1;
        n_compared++;
        if (sram_ready_o !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rst_ready_low: sram_ready_o=%b, required 0", sram_ready_o);
        end
        @(negedge mac_clk);
        #1;
        n_compared++;
        if (decoder_valid_o !== 1'b0 || decoder_data_o !== '0) begin
            n_mismatched++;
            $display("FAIL rst_output: valid=%b data=%h, required valid=0 data=0",
                     decoder_valid_o, decoder_data_o);
        end
        n_compared++;
        if (sram_ready_o !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rst_ready_held: sram_ready_o=%b, required 0", sram_ready_o);
        end
        @(negedge mac_clk);
        mac_rst = 1'b0;
        #1;
        n_compared++;
        if (sram_ready_o !== 1'b1 || decoder_valid_o !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rst_release: ready=%b valid=%b, required ready=1 valid=0",
                     sram_ready_o, decoder_valid_o);
        end
        exp_q.delete();
        model_cnt     = '0;
        stall_pending = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_spec_example();
        logic [INDEX_W-1:0] want_idx[5] = '{16'd5, 16'd10, 16'd11, 16'd22, 16'd24};
        logic [VALUE_W-1:0] want_val[5] = '{8'd3, 8'd6, 8'd9, 8'd1, 8'd7};
        out_log.delete();
        send(8'd5, 8'd3, 1);
        send(8'd4, 8'd6, 1);
        drain("example_a");
        send(8'd0, 8'd9, 1);
        send(8'd10, 8'd1, 1);
        send(8'd1, 8'd7, 1);
        drain("example_b");
        n_compared++;
        if (out_log.size() != 5) begin
            n_mismatched++;
            $display("FAIL example_count: %0d outputs, required 5", out_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (i >= out_log.size() || out_log[i].index !== want_idx[i] ||
                out_log[i].value !== want_val[i]) begin
                n_mismatched++;
                $display("FAIL example_beat%0d: got idx=%0d val=%0d, required idx=%0d val=%0d",
                         i, (i < out_log.size()) ? out_log[i].index : 16'hx,
                         (i < out_log.size()) ? out_log[i].value : 8'hx, want_idx[i], want_val[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_log.delete();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, SKIP_W'($urandom), VALUE_W'($urandom), bit'($urandom_range(0, 1)));
            end
            send(SKIP_W'($urandom_range(0, 15)), VALUE_W'($urandom_range(0, 255)), 2);
        end
        drain("backpressure");
        n_compared++;
        if (out_log.size() != 200) begin
            n_mismatched++;
            $display("FAIL backpressure_count: %0d outputs, required 200", out_log.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_log.delete();
        n_accept = 0;
        n_pop    = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, '0, VALUE_W'(i), 1'b1);
        end
        n_compared++;
        if (n_accept != 16) begin
            n_mismatched++;
            $display("FAIL b2b_accepts: %0d accepts in 16 cycles, required 16", n_accept);
        end
        cycle(1'b0, '0, '0, 1'b1);
        n_compared++;
        if (n_pop != 16) begin
            n_mismatched++;
            $display("FAIL b2b_outputs: %0d outputs in 17 cycles, required 16", n_pop);
        end
        for (int i = 0; i < 16; i++) begin
            n_compared++;
            if (i >= out_log.size() || out_log[i].index !== INDEX_W'(i)) begin
                n_mismatched++;
                $display("FAIL b2b_index%0d: got %0d, required %0d", i,
                         (i < out_log.size()) ? out_log[i].index : 16'hx, i);
            end
        end
        drain("b2b");
    endtask

    task automatic test_wrap();
        logic [INDEX_W-1:0] want;
        apply_reset();
        out_log.delete();
        for (int k = 0; k < 256; k++) begin
            send(8'd255, VALUE_W'(k), 1);
        end
        send(8'd255, 8'd1, 1);
        drain("wrap");
        for (int k = 0; k < 257; k++) begin
            want = INDEX_W'(k * 256 + 255);
            n_compared++;
            if (k >= out_log.size() || out_log[k].index !== want) begin
                n_mismatched++;
                $display("FAIL wrap_index%0d: got %0h, required %0h", k,
                         (k < out_log.size()) ? out_log[k].index : 16'hx, want);
            end
        end
    endtask

    task automatic test_reset_midstream();
        send(8'd2, 8'd1, 0);
        send(8'd7, 8'd2, 0);
        cycle(1'b0, '0, '0, 1'b0);
        n_compared++;
        if (decoder_valid_o !== 1'b1 || sram_ready_o !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midrst_full: valid=%b ready=%b, required valid=1 ready=0",
                     decoder_valid_o, sram_ready_o);
        end
        apply_reset();
        out_log.delete();
        send(8'd3, 8'd4, 1);
        drain("midrst");
        n_compared++;
        if (out_log.size() != 1 || out_log[0].index !== 16'd3 || out_log[0].value !== 8'd4) begin
            n_mismatched++;
            $display("FAIL midrst_first: %0d outputs, first idx=%0d val=%0d, required 1 output idx=3 val=4",
                     out_log.size(), (out_log.size() > 0) ? out_log[0].index : 16'hx,
                     (out_log.size() > 0) ? out_log[0].value : 8'hx);
        end
    endtask

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        model_cnt       = '0;
        stall_pending   = 1'b0;
        n_accept        = 0;
        n_pop           = 0;
        mac_rst         = 1'b1;
        sram_valid_i    = 1'b0;
        decoder_ready_i = 1'b0;
        sram_data_i     = '0;
        test_reset();
        test_spec_example();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
